// File: rtl/mwtxpkt_pkg.sv
// Shared definitions for the TX packet processor: packet slot size, read-FSM
// state encoding, the pad byte and the free-slot reporting helper.
package mwtxpkt_pkg;

  localparam int MAXPACKETLEN = 2048;
  localparam int SLOT_SHIFT   = $clog2(MAXPACKETLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;
  localparam logic [1:0] ST_IFG  = 2'd3;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  // Whole packet slots available in the given number of free entries, clipped to 8 bits.
  function automatic logic [7:0] canhold_slots(input logic [31:0] free_entries);
    logic [31:0] slots;
    slots = free_entries >> SLOT_SHIFT;
    return (slots > 32'd255) ? 8'hFF : slots[7:0];
  endfunction

endpackage

// File: rtl/mwtxsyncfifo.sv
// Single-clock packet RAM holding {eop,data} entries with a one-cycle registered
// read port; the read register holds its value whenever i_rd_en is low.
module mwtxsyncfifo #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_wr_en,
  input  logic [ADDRWIDTH-1:0] i_wr_addr,
  input  logic [DATAWIDTH:0]   i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDRWIDTH-1:0] i_rd_addr,
  output logic [DATAWIDTH:0]   o_rd_data
);

  logic [DATAWIDTH:0] r_mem [2**ADDRWIDTH];
  logic [DATAWIDTH:0] r_rd_data;

  // NOTE: the array has no reset so it maps onto block RAM; readers only see
  // entries that were written first, so power-up contents never escape.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mwtxpktproc.sv
// Store-and-forward TX packet processor between the arbiter and the TX MAC.
// Define MWTX_MINPAD_EN to zero-pad short frames up to MINPKTLEN bytes.
module mwtxpktproc
  import mwtxpkt_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 12,
  parameter int MINPKTLEN = 60,
  parameter int IFGCYCLES = 12
) (
  input  logic                 dutclk,
  input  logic                 reset,
  input  logic [DATAWIDTH-1:0] txbuffer_data,
  input  logic                 txbuffer_datavld,
  input  logic                 txbuffer_eop,
  output logic [DATAWIDTH-1:0] txdata,
  output logic                 txdatavalid,
  output logic                 txeop,
  input  logic                 txready,
  output logic                 txpkt_dropped,
  output logic [7:0]           numofpacket_txcanhold
);

  localparam logic [ADDRWIDTH:0] DEPTH    = (ADDRWIDTH+1)'(1 << ADDRWIDTH);
  localparam logic [ADDRWIDTH:0] PTR_ONE  = (ADDRWIDTH+1)'(1);
  localparam logic [11:0]        MIN_LEN  = 12'(MINPKTLEN);
  localparam logic [15:0]        IFG_LAST = 16'(IFGCYCLES - 1);

`ifdef MWTX_MINPAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic [ADDRWIDTH:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_ack_ptr, r_pkt_count;
  logic               r_dropping, r_dropped;
  logic [1:0]         r_state;
  logic [10:0]        r_byte_cnt;
  logic [15:0]        r_ifg_cnt;
  logic [7:0]         r_canhold;

  logic [DATAWIDTH:0] w_rd_q;
  logic [ADDRWIDTH:0] w_used, w_free;
  logic [10:0]        w_byte_cnt_inc;
  logic w_full, w_in, w_wr_en, w_drop, w_commit;
  logic w_accept, w_frame_end, w_start, w_rd_en, w_cur_eop, w_need_pad, w_pad_last;

  // Free space is measured against bytes the MAC has accepted, so a prefetched
  // byte keeps its RAM slot until it is really gone.
  assign w_used  = r_wr_ptr - r_ack_ptr;
  assign w_free  = DEPTH - w_used;
  assign w_full  = (r_wr_ptr[ADDRWIDTH] != r_ack_ptr[ADDRWIDTH]) &&
                   (r_wr_ptr[ADDRWIDTH-1:0] == r_ack_ptr[ADDRWIDTH-1:0]);

  assign w_in     = txbuffer_datavld && !r_dropping;
  assign w_wr_en  = w_in && !w_full;
  assign w_drop   = w_in && w_full;
  assign w_commit = w_wr_en && txbuffer_eop;

  assign w_cur_eop      = w_rd_q[DATAWIDTH];
  assign w_byte_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_need_pad     = PAD_EN && (({1'b0, r_byte_cnt} + 12'd1) < MIN_LEN);
  assign w_pad_last     = ({1'b0, r_byte_cnt} + 12'd1) >= MIN_LEN;

  assign txdatavalid = (r_state == ST_SEND) || (r_state == ST_PAD);
  assign txeop       = ((r_state == ST_SEND) && w_cur_eop && !w_need_pad) ||
                       ((r_state == ST_PAD) && w_pad_last);
  assign w_accept    = txdatavalid && txready;
  assign w_frame_end = w_accept && txeop;

  // A frame may start from IDLE or directly out of the last IFG cycle, which
  // keeps the gap at exactly IFGCYCLES.
  assign w_start = ((r_state == ST_IDLE) || ((r_state == ST_IFG) && (r_ifg_cnt == '0))) &&
                   (r_pkt_count != '0);
  assign w_rd_en = w_start || ((r_state == ST_SEND) && txready && !w_cur_eop);

  // NOTE: every output of this block is assigned a default first, so no latch
  // can be inferred on paths that do not drive it.
  always_comb begin
    txdata = '0;
    if (r_state == ST_SEND)     txdata = w_rd_q[DATAWIDTH-1:0];
    else if (r_state == ST_PAD) txdata = DATAWIDTH'(PAD_BYTE);
  end

  mwtxsyncfifo #(
    .DATAWIDTH(DATAWIDTH),
    .ADDRWIDTH(ADDRWIDTH)
  ) u_ram (
    .i_clk    (dutclk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr[ADDRWIDTH-1:0]),
    .i_wr_data({txbuffer_eop, txbuffer_data}),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr[ADDRWIDTH-1:0]),
    .o_rd_data(w_rd_q)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge dutclk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_dropping   <= 1'b0;
      r_dropped    <= 1'b0;
      r_pkt_count  <= '0;
      r_canhold    <= '0;
    end else begin
      r_dropped <= w_drop;
      if (w_drop) begin
        r_wr_ptr   <= r_commit_ptr;
        r_dropping <= !txbuffer_eop;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (r_dropping && txbuffer_datavld && txbuffer_eop) r_dropping <= 1'b0;
      if (w_commit) r_commit_ptr <= r_wr_ptr + PTR_ONE;
      case ({w_commit, w_frame_end})
        2'b10:   r_pkt_count <= r_pkt_count + PTR_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - PTR_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
      r_canhold <= w_full ? 8'd0 : canhold_slots(32'(w_free));
    end
  end

  always_ff @(posedge dutclk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_byte_cnt <= '0;
      r_ifg_cnt  <= '0;
      r_rd_ptr   <= '0;
      r_ack_ptr  <= '0;
    end else begin
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_accept && (r_state == ST_SEND)) r_ack_ptr <= r_ack_ptr + PTR_ONE;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_SEND;
            r_byte_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (w_accept) begin
            r_byte_cnt <= w_byte_cnt_inc;
            if (w_cur_eop) begin
              if (w_need_pad) begin
                r_state <= ST_PAD;
              end else begin
                r_state   <= ST_IFG;
                r_ifg_cnt <= IFG_LAST;
              end
            end
          end
        end
        ST_PAD: begin
          if (w_accept) begin
            r_byte_cnt <= w_byte_cnt_inc;
            if (txeop) begin
              r_state   <= ST_IFG;
              r_ifg_cnt <= IFG_LAST;
            end
          end
        end
        default: begin
          if (r_ifg_cnt != '0) begin
            r_ifg_cnt <= r_ifg_cnt - 16'd1;
          end else if (w_start) begin
            r_state    <= ST_SEND;
            r_byte_cnt <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign txpkt_dropped         = r_dropped;
  assign numofpacket_txcanhold = r_canhold;

endmodule

// File: tb/tb_mwtxpktproc.sv
// Self-checking bench for mwtxpktproc: random packets against a frame-level
// model (stored bytes, optional zero padding, eop on the last byte).
module tb_mwtxpktproc;

  localparam int MINLEN = 60;
  localparam int IFG    = 12;
`ifdef MWTX_MINPAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       dutclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txbuffer_data = '0;
  logic       txbuffer_datavld = 1'b0;
  logic       txbuffer_eop = 1'b0;
  logic [7:0] txdata;
  logic       txdatavalid, txeop, txpkt_dropped;
  logic       txready;
  logic [7:0] numofpacket_txcanhold;

  int checks = 0;
  int errors = 0;
  int ready_mode = 3;  // 0 always ready, 1 toggle, 2 random, 3 never

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int run_q[$];
  int gap_q[$];
  int run_cnt = 0, gap_cnt = 0, bubbles = 0, stall_err = 0, drop_cnt = 0;
  bit in_gap = 1'b0, prev_stall = 1'b0;
  logic [8:0] prev_out;

  mwtxpktproc dut (
    .dutclk               (dutclk),
    .reset                (reset),
    .txbuffer_data        (txbuffer_data),
    .txbuffer_datavld     (txbuffer_datavld),
    .txbuffer_eop         (txbuffer_eop),
    .txdata               (txdata),
    .txdatavalid          (txdatavalid),
    .txeop                (txeop),
    .txready              (txready),
    .txpkt_dropped        (txpkt_dropped),
    .numofpacket_txcanhold(numofpacket_txcanhold)
  );

  initial forever #5 dutclk = ~dutclk;

  initial begin
    txready = 1'b0;
    forever begin
      @(posedge dutclk); #1;
      case (ready_mode)
        0:       txready = 1'b1;
        1:       txready = ~txready;
        2:       txready = 1'($urandom);
        default: txready = 1'b0;
      endcase
    end
  end

  // Output monitor: collects accepted bytes, frame run lengths, gaps and hold violations.
  always @(negedge dutclk) begin
    if (reset) begin
      run_cnt = 0; in_gap = 1'b0; prev_stall = 1'b0; gap_cnt = 0;
    end else begin
      if (prev_stall && (!txdatavalid || {txeop, txdata} != prev_out)) stall_err++;
      if (txdatavalid) begin
        if (in_gap) begin gap_q.push_back(gap_cnt); in_gap = 1'b0; end
        run_cnt++;
        if (txready) begin
          got_q.push_back({txeop, txdata});
          if (txeop) begin
            run_q.push_back(run_cnt); run_cnt = 0; in_gap = 1'b1; gap_cnt = 0;
          end
        end
      end else begin
        if (in_gap) gap_cnt++;
        if (run_cnt != 0) bubbles++;
      end
      prev_stall = txdatavalid && !txready;
      prev_out   = {txeop, txdata};
      if (txpkt_dropped) drop_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_all();
    exp_q.delete(); got_q.delete(); run_q.delete(); gap_q.delete();
    bubbles = 0; stall_err = 0;
  endtask

  // Model: stored bytes in order, zero-padded to MINLEN when padding is on, eop on the last byte.
  task automatic send_pkt(input int len, input bit expect_drop);
    logic [8:0] fr[$];
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      @(posedge dutclk); #1;
      txbuffer_datavld = 1'b1; txbuffer_data = d; txbuffer_eop = (i == len - 1);
      fr.push_back({1'b0, d});
    end
    @(posedge dutclk); #1;
    txbuffer_datavld = 1'b0; txbuffer_eop = 1'b0;
    if (!expect_drop) begin
      if (PAD_EN) while (fr.size() < MINLEN) fr.push_back(9'h000);
      fr[fr.size() - 1][8] = 1'b1;
      foreach (fr[k]) exp_q.push_back(fr[k]);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin @(posedge dutclk); n++; end
    checks++;
    if (got_q.size() < exp_q.size()) begin
      errors++;
      $display("FAIL %s drain: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    end
    repeat (IFG + 4) @(posedge dutclk);
  endtask

  task automatic compare_stream(input string name);
    int bad = -1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s length: got %0d bytes, required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s byte %0d: got eop=%0b data=%02h, required eop=%0b data=%02h", name, bad,
               got_q[bad][8], got_q[bad][7:0], exp_q[bad][8], exp_q[bad][7:0]);
    end
    checks++;
    if (bubbles != 0 || stall_err != 0) begin
      errors++;
      $display("FAIL %s flow: got %0d bubbles %0d hold errors, required 0 0", name, bubbles, stall_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge dutclk);
    @(negedge dutclk);
    checks++;
    if ({txdatavalid, txeop, txpkt_dropped} !== 3'b000 || txdata !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: got valid=%0b eop=%0b drop=%0b data=%02h, required 0 0 0 00",
               txdatavalid, txeop, txpkt_dropped, txdata);
    end
    checks++;
    if (numofpacket_txcanhold !== 8'd0) begin
      errors++; $display("FAIL reset canhold: got %0d, required 0", numofpacket_txcanhold);
    end
    @(posedge dutclk); #1; reset = 1'b0;
    @(posedge dutclk); @(negedge dutclk);
    checks++;
    if (numofpacket_txcanhold !== 8'd2) begin
      errors++; $display("FAIL empty canhold: got %0d, required 2", numofpacket_txcanhold);
    end
  endtask

  task automatic test_single_64();
    clear_all(); ready_mode = 0;
    send_pkt(64, 1'b0);
    send_pkt(64, 1'b0);
    wait_drain("single64", 1000);
    compare_stream("single64");
    checks++;
    if (run_q.size() < 1 || run_q[0] != 64) begin
      errors++; $display("FAIL single64 run: got %0d valid cycles, required 64", run_q.size() ? run_q[0] : -1);
    end
    checks++;
    if (gap_q.size() < 1 || gap_q[0] != IFG) begin
      errors++; $display("FAIL single64 ifg: got %0d idle cycles, required %0d", gap_q.size() ? gap_q[0] : -1, IFG);
    end
  endtask

  task automatic test_short_pad();
    int want;
    clear_all(); ready_mode = 0;
    send_pkt(20, 1'b0);
    wait_drain("short20", 500);
    compare_stream("short20");
    want = PAD_EN ? MINLEN : 20;
    checks++;
    if (run_q.size() != 1 || run_q[0] != want) begin
      errors++; $display("FAIL short20 run: got %0d cycles, required %0d", run_q.size() ? run_q[0] : -1, want);
    end
  endtask

  task automatic test_ready_toggle();
    clear_all(); ready_mode = 1;
    send_pkt(100, 1'b0);
    wait_drain("toggle", 1000);
    compare_stream("toggle");
  endtask

  task automatic test_fill_drop();
    int d0;
    clear_all(); ready_mode = 3;
    send_pkt(2048, 1'b0);
    repeat (2) @(posedge dutclk); @(negedge dutclk);
    checks++;
    if (numofpacket_txcanhold !== 8'd1) begin
      errors++; $display("FAIL fill2048 canhold: got %0d, required 1", numofpacket_txcanhold);
    end
    send_pkt(2047, 1'b0);
    d0 = drop_cnt;
    send_pkt(100, 1'b1);
    repeat (2) @(posedge dutclk);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++; $display("FAIL drop pulse: got %0d cycles, required 1", drop_cnt - d0);
    end
    send_pkt(1, 1'b0);
    repeat (2) @(posedge dutclk); @(negedge dutclk);
    checks++;
    if (numofpacket_txcanhold !== 8'd0) begin
      errors++; $display("FAIL full canhold: got %0d, required 0", numofpacket_txcanhold);
    end
    ready_mode = 0;
    wait_drain("fill", 20000);
    compare_stream("fill");
    @(negedge dutclk);
    checks++;
    if (numofpacket_txcanhold !== 8'd2) begin
      errors++; $display("FAIL drained canhold: got %0d, required 2", numofpacket_txcanhold);
    end
  endtask

  task automatic test_commit_and_end();
    clear_all(); ready_mode = 3;
    send_pkt(10, 1'b0);
    send_pkt(10, 1'b0);
    repeat (4) @(posedge dutclk);
    ready_mode = 0;
    send_pkt(9, 1'b0);
    wait_drain("commit_end", 2000);
    repeat (40) @(posedge dutclk);
    compare_stream("commit_end");
    @(negedge dutclk);
    checks++;
    if (numofpacket_txcanhold !== 8'd2) begin
      errors++; $display("FAIL commit_end canhold: got %0d, required 2", numofpacket_txcanhold);
    end
  endtask

  task automatic test_random();
    int d0 = drop_cnt;
    clear_all(); ready_mode = 2;
    for (int p = 0; p < 10; p++) send_pkt(int'($urandom_range(1, 150)), 1'b0);
    wait_drain("random", 5000);
    compare_stream("random");
    checks++;
    if (drop_cnt != d0) begin
      errors++; $display("FAIL random drops: got %0d, required 0", drop_cnt - d0);
    end
  endtask

  task automatic test_reset_midframe();
    int n = 0, sz;
    bit saw_eop = 1'b0;
    clear_all(); ready_mode = 0;
    send_pkt(50, 1'b0);
    while (got_q.size() < 10 && n < 500) begin @(posedge dutclk); n++; end
    #1 reset = 1'b1;
    @(posedge dutclk); @(negedge dutclk);
    checks++;
    if (txdatavalid !== 1'b0 || txeop !== 1'b0) begin
      errors++; $display("FAIL midreset outputs: got valid=%0b eop=%0b, required 0 0", txdatavalid, txeop);
    end
    @(posedge dutclk); #1 reset = 1'b0;
    sz = got_q.size();
    foreach (got_q[i]) if (got_q[i][8]) saw_eop = 1'b1;
    checks++;
    if (sz < 10 || sz >= 50 || saw_eop) begin
      errors++; $display("FAIL midreset frame: got %0d bytes eop_seen=%0b, required partial with no eop", sz, saw_eop);
    end
    repeat (100) @(posedge dutclk);
    checks++;
    if (got_q.size() != sz) begin
      errors++; $display("FAIL midreset resume: got %0d bytes, required %0d", got_q.size(), sz);
    end
    clear_all();
  endtask

  initial begin
    test_reset();
    test_single_64();
    test_short_pad();
    test_ready_toggle();
    test_fill_drop();
    test_commit_and_end();
    test_random();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mwtxpktproc.md
MWTXPKTPROC -- requirements
Module: mwtxpktproc

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, byte width of the packet data path.
REQ-002 SHALL have parameter ADDRWIDTH, default 12, log2 of the packet buffer depth in entries.
REQ-003 SHALL have parameter MINPKTLEN, default 60, minimum transmitted frame length in bytes.
REQ-004 SHALL have parameter IFGCYCLES, default 12, idle cycles enforced between frames.
REQ-005 SHALL have ports, one per line:
  dutclk  in  1  sole clock; every register rises on it.
  reset  in  1  synchronous, active-high reset.
  txbuffer_data  in  DATAWIDTH  packet byte from the arbiter.
  txbuffer_datavld  in  1  txbuffer_data is valid this cycle.
  txbuffer_eop  in  1  last byte of packet; qualified by txbuffer_datavld.
  txdata  out  DATAWIDTH  byte to the TX MAC.
  txdatavalid  out  1  txdata is valid.
  txeop  out  1  last byte of frame; qualified by txdatavalid.
  txready  in  1  MAC accepts the byte when txdatavalid && txready.
  txpkt_dropped  out  1  one-cycle pulse when an input packet is discarded.
  numofpacket_txcanhold  out  8  whole 2048-byte packet slots currently free.
REQ-006 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-007 SHALL be store-and-forward: a frame is not started until its eop byte is committed to the buffer.
REQ-008 SHALL write each valid input byte as {eop,data} at wr_ptr; the committed pointer SHALL advance to wr_ptr+1 only on eop.
REQ-009 SHALL, when a byte arrives with the buffer full, discard the packet: wr_ptr rewinds to the committed pointer, remaining bytes up to and including eop are ignored, txpkt_dropped pulses once.
REQ-010 SHALL keep pkt_count (ADDRWIDTH+1 bits): +1 on commit, -1 on acceptance of the txeop byte; both in one cycle leaves it unchanged.
REQ-011 SHALL implement read FSM IDLE -> SEND (pkt_count>0) -> PAD (if REQ-018 applies) -> IFG -> IDLE.
REQ-012 SHALL in SEND present a prefetched byte on txdata with txdatavalid=1 and hold txdata/txeop stable until txready; the next byte SHALL be valid the following cycle (no bubbles).
REQ-013 SHALL count accepted bytes per frame in an 11-bit saturating counter.
REQ-014 SHALL in IFG hold txdatavalid=0 for exactly IFGCYCLES cycles after the last accepted byte.
REQ-015 SHALL wrap read and write pointers modulo 2**ADDRWIDTH; full/empty SHALL use an extra MSB.
REQ-016 SHALL compute numofpacket_txcanhold registered as free_entries>>11, forced to 0 while full, saturating at 255; value SHALL be one cycle behind pointer updates.

Reset
REQ-017 SHALL on reset: pointers, pkt_count, byte counter = 0; FSM = IDLE; txdata = 0, txdatavalid = 0, txeop = 0, txpkt_dropped = 0, numofpacket_txcanhold = 0; reset mid-frame SHALL abandon the frame without asserting txeop.

Configuration
REQ-018 With MWTX_MINPAD_EN defined, a frame shorter than MINPKTLEN SHALL have txeop withheld on its last stored byte, then PAD emits zero bytes until MINPKTLEN bytes total, txeop on the final pad byte.
REQ-019 Without MWTX_MINPAD_EN, PAD SHALL not exist and frames SHALL be sent at stored length.

Structure
REQ-020 SHALL place MAXPACKETLEN (2048), FSM state encoding and the pad byte value in shared package mwtxpkt_pkg.
REQ-021 SHALL instantiate one sub-module, mwtxsyncfifo: single-clock RAM, {eop,data} entries, one-cycle read latency, no packet logic.

Verification
REQ-022 One 64-byte packet, txready=1 -> 64 consecutive txdatavalid cycles, txeop on byte 64, then 12 idle cycles.
REQ-023 With MWTX_MINPAD_EN, 20-byte packet -> 20 data bytes plus 40 zero bytes, txeop on byte 60; without it, txeop on byte 20.
REQ-024 Fill buffer to 4095 entries, send a 100-byte packet -> txpkt_dropped one pulse, pkt_count and committed pointer unchanged, later packets correct.
REQ-025 txready toggling 1010... during a frame -> txdata stable while not ready, byte sequence intact, no duplicates.
REQ-026 Commit and frame-end on the same cycle with pkt_count=2 -> pkt_count stays 2; numofpacket_txcanhold = 1 with 2048 entries free, 0 when full.
